// File: rtl/if2id_buf_if.sv
// Fetch-to-decode buffer bus: PC-stage handshake, imem request/response, decode handshake.
// Signal names keep the block's external port names; the slave modport is the buffer itself.
// The master modport is the surrounding pipeline/memory environment.
interface if2id_buf_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_ifu_valid;
  logic [ADDR_WIDTH-1:0] i_ifu_pc;
  logic                  o_ifu_ready;
  logic                  i_exu_jmp_en;
  logic                  o_mem_req_valid;
  logic [ADDR_WIDTH-1:0] o_mem_req_addr;
  logic                  i_mem_req_ready;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;
  logic                  i_mem_rsp_err;
  logic                  o_idu_valid;
  logic [ADDR_WIDTH-1:0] o_idu_pc;
  logic [DATA_WIDTH-1:0] o_idu_inst;
  logic                  o_idu_exc;
  logic                  i_idu_ready;

  modport slave (
    input  i_ifu_valid, i_ifu_pc, i_exu_jmp_en, i_mem_req_ready,
           i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err, i_idu_ready,
    output o_ifu_ready, o_mem_req_valid, o_mem_req_addr,
           o_idu_valid, o_idu_pc, o_idu_inst, o_idu_exc
  );

  modport master (
    output i_ifu_valid, i_ifu_pc, i_exu_jmp_en, i_mem_req_ready,
           i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err, i_idu_ready,
    input  o_ifu_ready, o_mem_req_valid, o_mem_req_addr,
           o_idu_valid, o_idu_pc, o_idu_inst, o_idu_exc
  );
endinterface

// File: rtl/if2id_buf.sv
// Fetch-to-decode buffer: one outstanding imem read, responses queued with PC into a DEPTH FIFO.
// Latency: head valid 1 cycle after the imem response; best case one instruction per 2 cycles.
// Backpressure: no request while FIFO full; EXU redirect flushes FIFO and drops an in-flight read.
// Optional: define IF2ID_MISALIGN_CHK_EN to turn misaligned PCs into exception entries without imem access.
module if2id_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic       i_sys_clk,
  input logic       i_sys_rst,
  if2id_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
  logic                  exc_mem_q  [DEPTH];

  logic                  flush;
  logic                  has_space;
  logic                  issue_ok;
  logic                  misalign;
  logic                  req_valid;
  logic                  req_fire;
  logic                  mis_push;
  logic                  rsp_push;
  logic                  push;
  logic                  pop;
  logic                  head_vld;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [DATA_WIDTH-1:0] push_inst;
  logic                  push_exc;

  assign flush     = bus.i_exu_jmp_en;
  assign has_space = (count_q < CW'(DEPTH));

  // A new fetch may start only with nothing outstanding, a free slot guaranteed for its
  // response, and no redirect this cycle; reset also silences the upstream handshake.
  assign issue_ok  = (state_q == S_IDLE) & bus.i_ifu_valid & ~flush & has_space & ~i_sys_rst;

`ifdef IF2ID_MISALIGN_CHK_EN
  assign misalign  = |bus.i_ifu_pc[1:0];
`else
  assign misalign  = 1'b0;
`endif

  assign req_valid = issue_ok & ~misalign;
  assign mis_push  = issue_ok & misalign;
  assign req_fire  = req_valid & bus.i_mem_req_ready;

  assign bus.o_mem_req_valid = req_valid;
  assign bus.o_mem_req_addr  = bus.i_ifu_pc;
  // The PC stage steps once per accepted fetch (or faulted PC), and loads the target on redirect.
  assign bus.o_ifu_ready     = ~i_sys_rst & (flush | req_fire | mis_push);

  // Responses while DROP or IDLE never reach the FIFO; a redirect discards a same-cycle response.
  assign rsp_push  = (state_q == S_WAIT) & bus.i_mem_rsp_valid & ~flush;
  assign push      = rsp_push | mis_push;
  assign push_pc   = mis_push ? bus.i_ifu_pc : pc_q;
  assign push_inst = mis_push ? '0 : bus.i_mem_rsp_data;
  assign push_exc  = mis_push ? 1'b1 : bus.i_mem_rsp_err;

  assign head_vld  = (count_q != '0);
  assign pop       = head_vld & bus.i_idu_ready & ~flush;

  assign bus.o_idu_valid = head_vld;
  assign bus.o_idu_pc    = head_vld ? pc_mem_q[rd_ptr_q]   : '0;
  assign bus.o_idu_inst  = head_vld ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.o_idu_exc   = head_vld ? exc_mem_q[rd_ptr_q]  : 1'b0;

  // Fetch FSM: track the single outstanding read and whether its response is still wanted.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            state_q <= S_WAIT;
            pc_q    <= bus.i_ifu_pc;
          end
        end
        S_WAIT: begin
          if (bus.i_mem_rsp_valid) state_q <= S_IDLE;
          else if (flush)          state_q <= S_DROP;
        end
        S_DROP: begin
          if (bus.i_mem_rsp_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue and overrides any push/pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO control registers.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents need no reset since outputs are masked while the count is zero.
  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      inst_mem_q[wr_ptr_q] <= push_inst;
      exc_mem_q[wr_ptr_q]  <= push_exc;
    end
  end

endmodule

// File: tb/tb_if2id_buf.sv
// Directed, table-driven bench for if2id_buf: per-cycle input/expected-output vectors,
// plus hand-written sequences for a double redirect while dropping and the misaligned-PC path.
module tb_if2id_buf;

  localparam logic [31:0] B = 32'h8000_0000;

  typedef struct packed {
    logic        rst;
    logic        ifu_vld;
    logic [31:0] ifu_pc;
    logic        jmp;
    logic        req_rdy;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        idu_rdy;
  } in_t;

  typedef struct packed {
    logic        ifu_rdy;
    logic        req_vld;
    logic [31:0] req_addr;
    logic        idu_vld;
    logic [31:0] idu_pc;
    logic [31:0] idu_inst;
    logic        idu_exc;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  if2id_buf_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  if2id_buf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic r, input logic v, input logic [31:0] pc,
                                input logic j, input logic qr, input logic rv,
                                input logic [31:0] rd, input logic re, input logic ir);
    in_t x;
    x.rst = r; x.ifu_vld = v; x.ifu_pc = pc; x.jmp = j; x.req_rdy = qr;
    x.rsp_vld = rv; x.rsp_dat = rd; x.rsp_err = re; x.idu_rdy = ir;
    return x;
  endfunction

  function automatic out_t mk_out(input logic ir, input logic qv, input logic [31:0] qa,
                                  input logic iv, input logic [31:0] ipc,
                                  input logic [31:0] iinst, input logic iexc);
    out_t y;
    y.ifu_rdy = ir; y.req_vld = qv; y.req_addr = qa; y.idu_vld = iv;
    y.idu_pc = ipc; y.idu_inst = iinst; y.idu_exc = iexc;
    return y;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t x);
    rst                 = x.rst;
    bus.i_ifu_valid     = x.ifu_vld;
    bus.i_ifu_pc        = x.ifu_pc;
    bus.i_exu_jmp_en    = x.jmp;
    bus.i_mem_req_ready = x.req_rdy;
    bus.i_mem_rsp_valid = x.rsp_vld;
    bus.i_mem_rsp_data  = x.rsp_dat;
    bus.i_mem_rsp_err   = x.rsp_err;
    bus.i_idu_ready     = x.idu_rdy;
  endtask

  function automatic out_t sample();
    return mk_out(bus.o_ifu_ready, bus.o_mem_req_valid, bus.o_mem_req_addr,
                  bus.o_idu_valid, bus.o_idu_pc, bus.o_idu_inst, bus.o_idu_exc);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: ifu_rdy/req_vld/addr/idu_vld/pc/inst/exc got %b/%b/%h/%b/%h/%h/%b want %b/%b/%h/%b/%h/%h/%b",
               name, act.ifu_rdy, act.req_vld, act.req_addr, act.idu_vld, act.idu_pc, act.idu_inst, act.idu_exc,
               exp.ifu_rdy, exp.req_vld, exp.req_addr, exp.idu_vld, exp.idu_pc, exp.idu_inst, exp.idu_exc);
    end
  endtask

  // Inputs applied at the falling edge, outputs sampled 1 time unit later, then wait for the next falling edge.
  task automatic step(input string name, input in_t i, input out_t o);
    drive(i);
    #1;
    check(name, sample(), o);
    @(negedge clk);
  endtask

  initial begin
    // Reset check, then one fetch of B returning 0x13 (head visible the cycle after the response).
    add(mk_in(1,0,0,0,0,0,0,0,0),                    mk_out(0,0,0,0,0,0,0));
    add(mk_in(0,1,B,0,1,0,0,0,0),                    mk_out(1,1,B,0,0,0,0));
    add(mk_in(0,1,B+4,0,1,1,32'h13,0,0),             mk_out(0,0,B+4,0,0,0,0));
    add(mk_in(0,1,B+4,0,1,0,0,0,0),                  mk_out(1,1,B+4,1,B,32'h13,0));
    // Decode stalled: two entries fill the FIFO, third request held until a pop, drain in PC order.
    add(mk_in(0,1,B+8,0,1,1,32'h93,0,0),             mk_out(0,0,B+8,1,B,32'h13,0));
    add(mk_in(0,1,B+8,0,1,0,0,0,0),                  mk_out(0,0,B+8,1,B,32'h13,0));
    add(mk_in(0,1,B+8,0,1,0,0,0,1),                  mk_out(0,0,B+8,1,B,32'h13,0));
    add(mk_in(0,1,B+8,0,1,0,0,0,0),                  mk_out(1,1,B+8,1,B+4,32'h93,0));
    add(mk_in(0,1,B+12,0,1,1,32'h113,0,1),           mk_out(0,0,B+12,1,B+4,32'h93,0));
    add(mk_in(0,0,0,0,0,0,0,0,1),                    mk_out(0,0,0,1,B+8,32'h113,0));
    add(mk_in(0,0,0,0,0,0,0,0,0),                    mk_out(0,0,0,0,0,0,0));
    // Redirect while waiting: DROP, stale 0xDEADBEEF discarded, new PC fetched afterwards.
    add(mk_in(0,1,B+4,0,1,0,0,0,0),                  mk_out(1,1,B+4,0,0,0,0));
    add(mk_in(0,1,B+8,1,1,0,0,0,0),                  mk_out(1,0,B+8,0,0,0,0));
    add(mk_in(0,1,B+32'h100,0,1,0,0,0,0),            mk_out(0,0,B+32'h100,0,0,0,0));
    add(mk_in(0,1,B+32'h100,0,1,1,32'hDEAD_BEEF,0,0),mk_out(0,0,B+32'h100,0,0,0,0));
    add(mk_in(0,1,B+32'h100,0,1,0,0,0,0),            mk_out(1,1,B+32'h100,0,0,0,0));
    // Redirect coincident with a response in WAIT and one entry queued: everything cleared.
    add(mk_in(0,1,B+32'h104,0,0,1,32'h1111_1111,0,0),mk_out(0,0,B+32'h104,0,0,0,0));
    add(mk_in(0,1,B+32'h104,0,1,0,0,0,0),            mk_out(1,1,B+32'h104,1,B+32'h100,32'h1111_1111,0));
    add(mk_in(0,1,B+32'h108,1,1,1,32'h2222_2222,0,1),mk_out(1,0,B+32'h108,1,B+32'h100,32'h1111_1111,0));
    add(mk_in(0,1,B+32'h200,0,0,0,0,0,0),            mk_out(0,1,B+32'h200,0,0,0,0));
    // Access fault on the response surfaces as exc at the head.
    add(mk_in(0,1,B+32'h10,0,1,0,0,0,0),             mk_out(1,1,B+32'h10,0,0,0,0));
    add(mk_in(0,0,0,0,0,1,0,1,0),                    mk_out(0,0,0,0,0,0,0));
    add(mk_in(0,0,0,0,0,0,0,0,1),                    mk_out(0,0,0,1,B+32'h10,0,1));
    add(mk_in(0,0,0,0,0,0,0,0,0),                    mk_out(0,0,0,0,0,0,0));
    // Reset while in WAIT with one entry buffered; late response afterwards is ignored.
    add(mk_in(0,1,B+32'h20,0,1,0,0,0,0),             mk_out(1,1,B+32'h20,0,0,0,0));
    add(mk_in(0,0,0,0,0,1,32'h33,0,0),               mk_out(0,0,0,0,0,0,0));
    add(mk_in(0,1,B+32'h24,0,1,0,0,0,0),             mk_out(1,1,B+32'h24,1,B+32'h20,32'h33,0));
    add(mk_in(1,1,B+32'h28,0,1,0,0,0,0),             mk_out(0,0,B+32'h28,1,B+32'h20,32'h33,0));
    add(mk_in(0,0,0,0,0,1,32'h44,0,0),               mk_out(0,0,0,0,0,0,0));
    add(mk_in(0,0,0,0,0,0,0,0,0),                    mk_out(0,0,0,0,0,0,0));

    drive(mk_in(1,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);

    for (int k = 0; k < vecs.size(); k++)
      step($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);

    // Second redirect while already dropping: still exactly one response discarded.
    step("drop_req",   mk_in(0,1,B+32'h300,0,1,0,0,0,0),      mk_out(1,1,B+32'h300,0,0,0,0));
    step("drop_jmp1",  mk_in(0,1,B+32'h304,1,1,0,0,0,0),      mk_out(1,0,B+32'h304,0,0,0,0));
    step("drop_jmp2",  mk_in(0,1,B+32'h400,1,1,0,0,0,0),      mk_out(1,0,B+32'h400,0,0,0,0));
    step("drop_rsp",   mk_in(0,1,B+32'h500,0,1,1,32'h55,0,0), mk_out(0,0,B+32'h500,0,0,0,0));
    step("drop_newreq",mk_in(0,1,B+32'h500,0,1,0,0,0,0),      mk_out(1,1,B+32'h500,0,0,0,0));
    step("drop_newrsp",mk_in(0,0,0,0,0,1,32'h66,0,0),         mk_out(0,0,0,0,0,0,0));
    step("drop_head",  mk_in(0,0,0,0,0,0,0,0,1),              mk_out(0,0,0,1,B+32'h500,32'h66,0));

    // Misaligned PC handling.
`ifdef IF2ID_MISALIGN_CHK_EN
    step("mis_issue",  mk_in(0,1,B+32'h2,0,1,0,0,0,0),        mk_out(1,0,B+32'h2,0,0,0,0));
    step("mis_head",   mk_in(0,1,B+32'h8,0,0,0,0,0,1),        mk_out(0,1,B+32'h8,1,B+32'h2,0,1));
    step("mis_empty",  mk_in(0,0,0,0,0,0,0,0,0),              mk_out(0,0,0,0,0,0,0));
`else
    step("mis_issue",  mk_in(0,1,B+32'h2,0,1,0,0,0,0),        mk_out(1,1,B+32'h2,0,0,0,0));
    step("mis_rsp",    mk_in(0,0,0,0,0,1,32'h77,0,0),         mk_out(0,0,0,0,0,0,0));
    step("mis_head",   mk_in(0,0,0,0,0,0,0,0,1),              mk_out(0,0,0,1,B+32'h2,32'h77,0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
